bcd_timer3: RTL and testbench

Three-digit BCD countdown timer (000–999) for the counter/timer section of the design. It is the decrementing counterpart of the decimal up-counter chain: it loads a BCD start value, counts down one step per qualified `dec` tick while running, borrows across digits, and emits a one-cycle `done` pulse on reaching 000. Typical use: the `dec` tick comes from a prescaler, and `q` drives the 7-segment decoders.

---
 rtl/bcd_timer3_if.sv | 45 ++++
 rtl/bcd_timer3.sv | 120 ++++++++++++
 tb/tb_bcd_timer3.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_timer3_if.sv
// Bundle of control and status signals for the three-digit BCD countdown timer.
//
// Signals:
//   load   - load ld_val into the counter (highest priority)
//   ld_val - BCD start value: [11:8] hundreds, [7:4] tens, [3:0] ones
//   start  - begin countdown (only acts when idle)
//   dec    - decrement qualifier, one step per cycle high while running
//   q      - current BCD count (registered)
//   zero   - q == 000 (combinational)
//   busy   - high while counting down (registered)
//   done   - one-cycle pulse when the count reaches 000 (registered)
//
// master: the controller driving the timer; slave: the timer itself.
interface bcd_timer3_if;
    logic        load;
    logic [11:0] ld_val;
    logic        start;
    logic        dec;
    logic [11:0] q;
    logic        zero;
    logic        busy;
    logic        done;

    modport master (
        output load,
        output ld_val,
        output start,
        output dec,
        input  q,
        input  zero,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  ld_val,
        input  start,
        input  dec,
        output q,
        output zero,
        output busy,
        output done
    );
endinterface

// File: rtl/bcd_timer3.sv
// Three-digit BCD countdown timer (000-999).
//
// Loads a BCD start value (each digit saturated to 9), counts down one step per
// cycle that dec is high while running, borrows across digits and emits a
// one-cycle done pulse when the count reaches 000. The count never wraps.
//
// Ports:
//   CLK - system clock, rising edge
//   RST - asynchronous, active-high reset (count 000, idle, no done)
//   bus - bcd_timer3_if slave modport: load/ld_val/start/dec in,
//         q/zero/busy/done out
module bcd_timer3 (
    input  logic        CLK,
    input  logic        RST,
    bcd_timer3_if.slave bus
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e      state_q;
    logic [11:0] q_q;
    logic        busy_q;
    logic        done_q;

    logic [11:0] ld_sat;
    logic [11:0] q_dec;
    logic        q_dec_zero;

    // Clamp a non-decimal nibble (A-F) to 9 so q always holds valid BCD.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        logic [3:0] r;
        r = (d > 4'd9) ? 4'd9 : d;
        return r;
    endfunction

    // One BCD decrement with borrow ripple. 000 is held rather than wrapped; in
    // practice the FSM never decrements from 000 because RUN is left on reaching it.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (v != 12'h000) begin
            if (o != 4'd0) begin
                o = o - 4'd1;
            end else begin
                o = 4'd9;
                if (t != 4'd0) begin
                    t = t - 4'd1;
                end else begin
                    t = 4'd9;
                    h = h - 4'd1;
                end
            end
        end
        return {h, t, o};
    endfunction

    always_comb begin
        ld_sat     = {sat_digit(bus.ld_val[11:8]),
                      sat_digit(bus.ld_val[7:4]),
                      sat_digit(bus.ld_val[3:0])};
        q_dec      = bcd_dec(q_q);
        q_dec_zero = (q_dec == 12'h000);
    end

    // Single registered FSM: state, count and status flags all update together,
    // so done, busy falling and q == 000 appear after the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            q_q     <= 12'h000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                // Load aborts any countdown silently.
                q_q     <= ld_sat;
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        // Starting from 000 would finish immediately; ignore it.
                        if (bus.start && (q_q != 12'h000)) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (bus.dec) begin
                            q_q <= q_dec;
                            if (q_dec_zero) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q    = q_q;
    assign bus.zero = (q_q == 12'h000);
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_timer3.sv
// Bench for bcd_timer3: directed scenarios plus random stimulus, checked by a
// scoreboard against an integer-count reference model.
module tb_bcd_timer3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    bit   clk_en = 1'b0;

    bcd_timer3_if bus ();

    bcd_timer3 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 if (clk_en) CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] q;
        logic        busy;
        logic        done;
        logic        zero;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integer count and a running flag.
    int    m_cnt  = 0;
    bit    m_run  = 0;
    bit    m_done = 0;
    string phase  = "init";

    function automatic int sat9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic logic [11:0] to_bcd(input int c);
        logic [11:0] r;
        r[11:8] = 4'(c / 100);
        r[7:4]  = 4'((c / 10) % 10);
        r[3:0]  = 4'(c % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_run  = 0;
        m_done = 0;
    endtask

    task automatic step(input bit ld, input logic [11:0] v, input bit st, input bit dc);
        exp_t e;
        bus.load   = ld;
        bus.ld_val = v;
        bus.start  = st;
        bus.dec    = dc;
        m_done = 0;
        if (ld) begin
            m_cnt = sat9(int'(v[11:8])) * 100 + sat9(int'(v[7:4])) * 10 + sat9(int'(v[3:0]));
            m_run = 0;
        end else if (!m_run) begin
            if (st && m_cnt != 0) m_run = 1;
        end else if (dc) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_run  = 0;
                m_done = 1;
            end
        end
        e.cyc  = cyc + 1;
        e.q    = to_bcd(m_cnt);
        e.busy = m_run;
        e.done = m_done;
        e.zero = (m_cnt == 0);
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_now(input string name, input logic [11:0] q, input logic busy,
                             input logic done, input logic zero);
        n_cmp++;
        if (bus.q !== q || bus.busy !== busy || bus.done !== done || bus.zero !== zero) begin
            n_bad++;
            $display("FAIL %s: got q=%h busy=%b done=%b zero=%b, expected q=%h busy=%b done=%b zero=%b",
                     name, bus.q, bus.busy, bus.done, bus.zero, q, busy, done, zero);
        end
    endtask

    // Monitor: pops every expectation due this cycle and checks BCD validity.
    exp_t  cur;
    string cur_tag;
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur     = exp_q.pop_front();
            cur_tag = tag_q.pop_front();
            n_cmp++;
            if (cur.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: stale expectation for cycle %0d at cycle %0d",
                         cur_tag, cur.cyc, cyc);
            end else if (bus.q !== cur.q || bus.busy !== cur.busy ||
                         bus.done !== cur.done || bus.zero !== cur.zero) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got q=%h busy=%b done=%b zero=%b, expected q=%h busy=%b done=%b zero=%b",
                         cur_tag, cyc, bus.q, bus.busy, bus.done, bus.zero,
                         cur.q, cur.busy, cur.done, cur.zero);
            end
        end
        n_cmp++;
        if (bus.q[11:8] > 4'd9 || bus.q[7:4] > 4'd9 || bus.q[3:0] > 4'd9 || $isunknown(bus.q)) begin
            n_bad++;
            $display("FAIL bcd_valid cyc %0d: got q=%h, required decimal digits", cyc, bus.q);
        end
    end

    initial begin
        bus.load   = 1'b0;
        bus.ld_val = 12'h000;
        bus.start  = 1'b0;
        bus.dec    = 1'b0;

        // Reset with the clock stopped must act immediately.
        #1 RST = 1'b1;
        #1 check_now("reset_no_clock", 12'h000, 1'b0, 1'b0, 1'b1);
        clk_en = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();

        phase = "start_at_zero";
        step(0, 12'h000, 1, 0);
        step(0, 12'h000, 0, 1);

        phase = "basic_countdown";
        step(1, 12'h003, 0, 0);
        step(0, 12'h000, 1, 0);
        repeat (5) step(0, 12'h000, 0, 1);

        phase = "borrow_100";
        step(1, 12'h100, 0, 0);
        step(0, 12'h000, 1, 1);
        repeat (2) step(0, 12'h000, 0, 1);

        phase = "borrow_010";
        step(1, 12'h010, 0, 0);
        step(0, 12'h000, 1, 0);
        step(0, 12'h000, 1, 1);

        phase = "saturate_A5F";
        step(1, 12'hA5F, 1, 1);
        step(0, 12'h000, 0, 0);

        phase = "pause_abort";
        step(1, 12'h020, 0, 0);
        step(0, 12'h000, 1, 0);
        step(0, 12'h000, 0, 1);
        step(0, 12'h000, 0, 0);
        step(0, 12'h000, 0, 0);
        step(0, 12'h000, 0, 1);
        step(1, 12'h007, 0, 1);
        step(0, 12'h000, 0, 1);

        phase = "full_range";
        step(1, 12'h999, 0, 0);
        step(0, 12'h000, 1, 0);
        repeat (1001) step(0, 12'h000, 0, 1);

        phase = "async_reset_mid_run";
        step(1, 12'h050, 0, 0);
        step(0, 12'h000, 1, 0);
        repeat (10) step(0, 12'h000, 0, 1);
        @(negedge CLK);
        #1 check_now("pre_reset_040", 12'h040, 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        #1 check_now("async_reset_mid_run", 12'h000, 1'b0, 1'b0, 1'b1);
        #1 RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;

        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            bit          ld;
            bit          st;
            bit          dc;
            logic [11:0] v;
            ld = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) v = {8'h00, 4'($urandom_range(0, 15))};
            else v = 12'($urandom);
            st = ($urandom_range(0, 3) == 0);
            dc = ($urandom_range(0, 4) != 0);
            step(ld, v, st, dc);
        end

        repeat (3) @(negedge CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
